// File: rtl/truth_table_probe_pkg.sv
// truth_table_probe_pkg
// Shared types and limits for the truth-table probe.
//   state_e    : sweep controller states
//   N_IN_MAX   : largest supported number of probed inputs
//   SETTLE_MAX : largest supported settle time in cycles
//   CNT_W      : width of the settle counter
package truth_table_probe_pkg;

  localparam int unsigned N_IN_MAX   = 3;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } state_e;

endpackage

// File: rtl/probe_settle_timer.sv
// probe_settle_timer
// Load/decrement counter that paces each minterm window. Counts down to zero
// and holds there until reloaded.
//   i_clk   : clock
//   i_reset : synchronous active-high reset, clears the count
//   i_load  : load i_value (takes priority over decrement)
//   i_value : reload value
//   o_zero  : count is zero, the current window closes on this edge
module probe_settle_timer
  import truth_table_probe_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_probe.sv
// truth_table_probe
// Drives every input minterm of a small combinational gate in ascending order,
// samples its output after SETTLE extra cycles per minterm and reports the
// observed truth table together with a comparison against an expected table.
//   i_clk       : clock
//   i_reset     : synchronous active-high reset, aborts any sweep
//   i_start     : request a sweep (accepted only when idle)
//   i_expected  : expected table, bit m = output for minterm m, captured at start
//   o_x         : gate input vector (MSB = MSB of minterm index)
//   i_s         : gate output
//   o_busy      : sweep in progress
//   o_done      : one-cycle pulse, results valid from here on
//   o_table     : observed table, held until the next accepted start
//   o_match     : observed table equals captured expected table
//   o_mismatch  : observed table XOR captured expected table
module truth_table_probe
  import truth_table_probe_pkg::*;
#(
  parameter  int unsigned N_IN   = 2,
  parameter  int unsigned SETTLE = 1,
  localparam int unsigned W      = 1 << N_IN
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [W-1:0]    i_expected,
  output logic [N_IN-1:0] o_x,
  input  logic            i_s,
  output logic            o_busy,
  output logic            o_done,
  output logic [W-1:0]    o_table,
  output logic            o_match,
  output logic [W-1:0]    o_mismatch
);

  // Index is one bit wider than needed so the last minterm is found by compare.
  localparam int unsigned MW = N_IN + 1;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("truth_table_probe: N_IN out of range 1..3");
  end
  if (SETTLE > SETTLE_MAX) begin : g_bad_settle
    $error("truth_table_probe: SETTLE out of range 0..15");
  end

  state_e        r_state, w_state_next;
  logic [MW-1:0] r_m;
  logic [W-1:0]  r_exp, r_table, r_mismatch, w_table_next;
  logic          r_match;
  logic          w_accept, w_sample, w_load, w_zero, w_last;

  probe_settle_timer u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_value (SETTLE_CNT),
    .o_zero  (w_zero)
  );

  assign w_last = (r_m == MW'(W - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_load       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_load       = 1'b1;
          w_state_next = StApply;
        end
      end
      StApply: begin
        // Window closes when the settle count has run out.
        if (w_zero) begin
          w_sample = 1'b1;
          if (w_last) begin
            w_state_next = StDone;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_table_next                  = r_table;
    w_table_next[r_m[N_IN-1:0]]   = i_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_m        <= '0;
      r_exp      <= '0;
      r_table    <= '0;
      r_match    <= 1'b0;
      r_mismatch <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_exp      <= i_expected;
        r_table    <= '0;
        r_m        <= '0;
        r_match    <= 1'b0;
        r_mismatch <= '0;
      end
      if (w_sample) begin
        r_table <= w_table_next;
        if (w_last) begin
          // Compare includes the final sample so results are valid in StDone.
          r_match    <= (w_table_next == r_exp);
          r_mismatch <= w_table_next ^ r_exp;
        end else begin
          r_m <= r_m + MW'(1);
        end
      end
    end
  end

  assign o_x        = (r_state == StIdle) ? '0 : r_m[N_IN-1:0];
  assign o_busy     = (r_state == StApply);
  assign o_done     = (r_state == StDone);
  assign o_table    = r_table;
  assign o_match    = r_match;
  assign o_mismatch = r_mismatch;

endmodule
